multi_lane_seed_counter: RTL and testbench
==========================================

# multi_lane_seed_counter

Parametrised successor to the single-hopper seed counter. Counts seeds per hole on NUM_CH independent IR lanes, one per hopper on a multi-row planter. Each lane provides:
- counter-based debounce;
- pulse-width classification into noise, seed or jam;
- a per-hole arm/fill/close state machine with overdrop detection.

It sits between the IR sensor front end and the sowing controller. The controller arms a lane when the hole is opened and closes it when the hole is covered.

## Interface
Parameters:
- NUM_CH, 4: number of sensor lanes (1–16)
- CLOCK_FREQ, 50000000: clk frequency in Hz
- MIN_PULSE_US, 10: shortest valid seed pulse; MIN_CYC = CLOCK_FREQ/1e6*MIN_PULSE_US
- MAX_PULSE_US, 500: longest valid seed pulse; MAX_CYC likewise
- DEBOUNCE_CYCLES, 100: consecutive disagreeing samples needed to flip a lane's stable value (≥2)

Ports (clock and reset first):
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- sensor_n  in  NUM_CH  raw IR inputs, active-low (0 = beam broken)
- sensor_enable  in  1  global enable; 0 freezes debounce, aborts pulses, blocks counting
- start  in  NUM_CH  per-lane arm pulse
- stop  in  NUM_CH  per-lane close pulse
- clear  in  1  synchronous clear of all counters and sticky flags
- target  in  8*NUM_CH  per-lane seeds-per-hole; lane i uses bits [8i+7:8i]; sampled on start
- seed_count  out  8*NUM_CH  per-lane seeds in current hole, saturates at 255
- target_reached  out  NUM_CH  lane is in FULL
- busy  out  NUM_CH  lane is in ARMED or FULL
- hole_done  out  NUM_CH  1-cycle pulse when a lane closes
- jam  out  NUM_CH  sticky: pulse exceeded MAX_CYC
- overdrop  out  NUM_CH  sticky: seed arrived while FULL
- total_seeds  out  32  all counted seeds, all lanes, saturating
- hole_count  out  16  all closed holes, all lanes, wrapping
- noise_count  out  16  all pulses shorter than MIN_CYC, saturating

## Operation
Reset: every output is 0, every lane state is IDLE, stable = 1, and all internal counters are 0.

Debounce (per lane):
- A counter increments while raw ≠ stable and clears when raw = stable.
- When the counter reaches DEBOUNCE_CYCLES, stable toggles and the counter clears.
- Edges are stable falling and stable rising, each lasting one cycle.

Pulse width:
- W = number of cycles stable was 0, saturating at MAX_CYC+1.
- On rising edge:
  - W < MIN_CYC: noise, increment noise_count.
  - MIN_CYC ≤ W ≤ MAX_CYC: seed event.
  - W > MAX_CYC: nothing.
- When W first reaches MAX_CYC+1, set jam[i]. Lane state is unchanged.

Lane FSM states: IDLE, ARMED, FULL.
- IDLE + start: latch target, seed_count=0, go to ARMED. If the latched target is 0, go directly to FULL.
- ARMED + seed: seed_count+1 and total+1. If seed_count+1 ≥ target, go to FULL.
- FULL + seed: seed_count+1 (saturating), total+1, set overdrop.
- ARMED/FULL + stop: go to IDLE, pulse hole_done, hole_count+1. seed_count holds until the next start.
- stop in IDLE: ignored.
- Seeds in IDLE: ignored for counting. Noise and jam are still recorded.

Priority: clear > start > stop > seed.
- start in ARMED/FULL restarts the hole (count 0, re-latch target, no hole_done). It also clears jam and overdrop for that lane.
- A seed in the same cycle as start or stop is dropped.
- clear zeroes seed_count, total_seeds, hole_count, noise_count, jam and overdrop, and returns all lanes to IDLE. It does not touch debounce state.

Multiple lanes in one cycle:
- total_seeds adds the number of lanes counting a seed.
- hole_count adds the number of lanes closing.

sensor_enable = 0:
- Debounce counters hold.
- Active pulses are discarded (W = 0) and no classification occurs.
- FSMs still accept start/stop.

## Timing
- Raw change to stable change: DEBOUNCE_CYCLES cycles, given a constant input.
- Stable rising edge to seed_count/total_seeds update: 1 cycle, so raw rising to count is DEBOUNCE_CYCLES+1 cycles.
- target_reached is asserted in the same cycle that seed_count reaches target.
- start/stop to state/busy change: 1 cycle. hole_done is asserted the cycle after stop, for 1 cycle.
- jam is asserted 1 cycle after W reaches MAX_CYC+1.
- rst_n asserted mid-hole: immediate return to reset values. No hole_done is issued.

## Test plan
Bench settings: NUM_CH=2, CLOCK_FREQ=1000000, MIN=10, MAX=50, DEBOUNCE_CYCLES=4.
- Start lane 0 with target=2, then two 20-cycle low pulses on lane 0 → seed_count0 = 1 then 2, target_reached[0] = 1, total_seeds = 2, busy = 01.
- Third 20-cycle pulse on lane 0 while FULL, then stop[0] → seed_count0 = 3, overdrop[0] = 1, hole_done[0] high 1 cycle, hole_count = 1.
- Glitches on lane 1: a 3-cycle low gives no stable change. A 6-cycle low gives noise_count = 1 and seed_count1 = 0.
- Lane 1 held low for 60 cycles while ARMED → jam[1] = 1, no seed counted. A later start[1] clears jam[1].
- Both lanes emit a valid pulse in the same cycle → total_seeds += 2. Stop on both lanes in the same cycle → hole_count += 2.
- target = 0 on start → FULL the next cycle. start coincident with a seed edge → seed dropped, seed_count = 0. clear mid-hole → all counters 0 and lanes IDLE.

Source files
------------

// File: rtl/multi_lane_seed_counter.sv
// Multi-lane seed counter: per-lane debounce, pulse-width classification
// and per-hole arm/fill/close FSM feeding shared statistics counters.
module multi_lane_seed_counter #(
    parameter int NUM_CH          = 4,
    parameter int CLOCK_FREQ      = 50000000,
    parameter int MIN_PULSE_US    = 10,
    parameter int MAX_PULSE_US    = 500,
    parameter int DEBOUNCE_CYCLES = 100
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_CH-1:0]   sensor_n,
    input  logic                sensor_enable,
    input  logic [NUM_CH-1:0]   start,
    input  logic [NUM_CH-1:0]   stop,
    input  logic                clear,
    input  logic [8*NUM_CH-1:0] target,
    output logic [8*NUM_CH-1:0] seed_count,
    output logic [NUM_CH-1:0]   target_reached,
    output logic [NUM_CH-1:0]   busy,
    output logic [NUM_CH-1:0]   hole_done,
    output logic [NUM_CH-1:0]   jam,
    output logic [NUM_CH-1:0]   overdrop,
    output logic [31:0]         total_seeds,
    output logic [15:0]         hole_count,
    output logic [15:0]         noise_count
);

    localparam int MIN_CYC = (CLOCK_FREQ / 1000000) * MIN_PULSE_US;
    localparam int MAX_CYC = (CLOCK_FREQ / 1000000) * MAX_PULSE_US;
    localparam int WW      = $clog2(MAX_CYC + 2);
    localparam int DW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CW      = $clog2(NUM_CH + 1);

    localparam logic [WW-1:0] W_MIN     = WW'(MIN_CYC);
    localparam logic [WW-1:0] W_MAX     = WW'(MAX_CYC);
    localparam logic [WW-1:0] W_SAT     = WW'(MAX_CYC + 1);
    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    // Debounce state
    logic [DW-1:0]     dcnt_q [NUM_CH];
    logic [DW-1:0]     dcnt_d [NUM_CH];
    logic [NUM_CH-1:0] stable_q, stable_d;
    logic [NUM_CH-1:0] prev_q;
    logic [NUM_CH-1:0] rise;

    // Pulse-width measurement
    logic [WW-1:0]     w_q [NUM_CH];
    logic [WW-1:0]     w_d [NUM_CH];
    logic [NUM_CH-1:0] jhit_q, jhit_d;
    logic [NUM_CH-1:0] seed_ev, noise_ev;

    // Lane FSM and per-lane outputs
    state_t            st_q  [NUM_CH];
    state_t            st_d  [NUM_CH];
    logic [7:0]        tgt_q [NUM_CH];
    logic [7:0]        tgt_d [NUM_CH];
    logic [7:0]        cnt_q [NUM_CH];
    logic [7:0]        cnt_d [NUM_CH];
    logic [NUM_CH-1:0] jam_q, jam_d;
    logic [NUM_CH-1:0] od_q, od_d;
    logic [NUM_CH-1:0] done_q, done_d;
    logic [NUM_CH-1:0] cnt_ev, close_ev;

    // Shared statistics
    logic [31:0]       total_q, total_d;
    logic [15:0]       holes_q, holes_d;
    logic [15:0]       noise_q, noise_d;
    logic [CW-1:0]     n_seed, n_close, n_noise;
    logic [32:0]       total_sum;
    logic [16:0]       noise_sum;

    function automatic logic [CW-1:0] popc(input logic [NUM_CH-1:0] v);
        logic [CW-1:0] s;
        s = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            s = s + CW'(v[k]);
        end
        return s;
    endfunction

    assign rise = stable_q & ~prev_q;

    // Debounce: count disagreeing samples and flip stable after enough of them
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NUM_CH; i++) begin
            dcnt_d[i] = dcnt_q[i];
            if (sensor_enable) begin
                if (sensor_n[i] == stable_q[i]) begin
                    dcnt_d[i] = '0;
                end else if (dcnt_q[i] == DCNT_LAST) begin
                    dcnt_d[i]   = '0;
                    stable_d[i] = ~stable_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Pulse width: measure low time, classify it on the stable rising edge
    always_comb begin
        seed_ev  = '0;
        noise_ev = '0;
        jhit_d   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_d[i] = '0;
            if (sensor_enable) begin
                if (!stable_q[i]) begin
                    w_d[i]    = (w_q[i] == W_SAT) ? W_SAT : w_q[i] + 1'b1;
                    jhit_d[i] = (w_q[i] == W_MAX);
                end else if (rise[i]) begin
                    if (w_q[i] < W_MIN) begin
                        noise_ev[i] = 1'b1;
                    end else if (w_q[i] <= W_MAX) begin
                        seed_ev[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Lane FSM: clear > start > stop > seed
    always_comb begin
        jam_d    = jam_q | jhit_q;
        od_d     = od_q;
        done_d   = '0;
        cnt_ev   = '0;
        close_ev = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            st_d[i]  = st_q[i];
            tgt_d[i] = tgt_q[i];
            cnt_d[i] = cnt_q[i];
            if (clear) begin
                st_d[i]  = S_IDLE;
                cnt_d[i] = '0;
                jam_d[i] = 1'b0;
                od_d[i]  = 1'b0;
            end else if (start[i]) begin
                tgt_d[i] = target[8*i +: 8];
                cnt_d[i] = '0;
                jam_d[i] = 1'b0;
                od_d[i]  = 1'b0;
                st_d[i]  = (target[8*i +: 8] == 8'd0) ? S_FULL : S_ARMED;
            end else if (stop[i] && st_q[i] != S_IDLE) begin
                st_d[i]     = S_IDLE;
                done_d[i]   = 1'b1;
                close_ev[i] = 1'b1;
            end else if (seed_ev[i]) begin
                unique case (st_q[i])
                    S_ARMED: begin
                        cnt_d[i]  = cnt_q[i] + 8'd1;
                        cnt_ev[i] = 1'b1;
                        if (({1'b0, cnt_q[i]} + 9'd1) >= {1'b0, tgt_q[i]}) begin
                            st_d[i] = S_FULL;
                        end
                    end
                    S_FULL: begin
                        if (cnt_q[i] != 8'hFF) begin
                            cnt_d[i] = cnt_q[i] + 8'd1;
                        end
                        cnt_ev[i] = 1'b1;
                        od_d[i]   = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Shared counters: saturating seeds and noise, wrapping holes
    always_comb begin
        n_seed    = popc(cnt_ev);
        n_close   = popc(close_ev);
        n_noise   = popc(noise_ev);
        total_sum = {1'b0, total_q} + 33'(n_seed);
        noise_sum = {1'b0, noise_q} + 17'(n_noise);
        if (clear) begin
            total_d = '0;
            holes_d = '0;
            noise_d = '0;
        end else begin
            total_d = total_sum[32] ? 32'hFFFF_FFFF : total_sum[31:0];
            holes_d = holes_q + 16'(n_close);
            noise_d = noise_sum[16] ? 16'hFFFF : noise_sum[15:0];
        end
    end

    // Debounce and pulse-width registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= '1;
            prev_q   <= '1;
            jhit_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                dcnt_q[i] <= '0;
                w_q[i]    <= '0;
            end
        end else begin
            stable_q <= stable_d;
            prev_q   <= stable_q;
            jhit_q   <= jhit_d;
            for (int i = 0; i < NUM_CH; i++) begin
                dcnt_q[i] <= dcnt_d[i];
                w_q[i]    <= w_d[i];
            end
        end
    end

    // Lane FSM and sticky flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jam_q  <= '0;
            od_q   <= '0;
            done_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                st_q[i]  <= S_IDLE;
                tgt_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            jam_q  <= jam_d;
            od_q   <= od_d;
            done_q <= done_d;
            for (int i = 0; i < NUM_CH; i++) begin
                st_q[i]  <= st_d[i];
                tgt_q[i] <= tgt_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Shared statistics registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_q <= '0;
            holes_q <= '0;
            noise_q <= '0;
        end else begin
            total_q <= total_d;
            holes_q <= holes_d;
            noise_q <= noise_d;
        end
    end

    // Per-lane output packing
    always_comb begin
        seed_count     = '0;
        target_reached = '0;
        busy           = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            seed_count[8*i +: 8] = cnt_q[i];
            target_reached[i]    = (st_q[i] == S_FULL);
            busy[i]              = (st_q[i] != S_IDLE);
        end
    end

    assign hole_done   = done_q;
    assign jam         = jam_q;
    assign overdrop    = od_q;
    assign total_seeds = total_q;
    assign hole_count  = holes_q;
    assign noise_count = noise_q;

endmodule

// File: tb/tb_multi_lane_seed_counter.sv
// Bench for multi_lane_seed_counter: directed scenarios with literal
// expectations plus random traffic against an event-level lane model.
module tb_multi_lane_seed_counter;

    localparam int N    = 2;
    localparam int D    = 4;
    localparam int MINC = 10;
    localparam int MAXC = 50;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   sensor_n = '1;
    logic           sensor_enable = 1'b1;
    logic [N-1:0]   start = '0;
    logic [N-1:0]   stop = '0;
    logic           clear = 1'b0;
    logic [8*N-1:0] target = '0;
    logic [8*N-1:0] seed_count;
    logic [N-1:0]   target_reached, busy, hole_done, jam, overdrop;
    logic [31:0]    total_seeds;
    logic [15:0]    hole_count, noise_count;

    multi_lane_seed_counter #(
        .NUM_CH(N), .CLOCK_FREQ(1000000), .MIN_PULSE_US(10),
        .MAX_PULSE_US(50), .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sensor_n(sensor_n),
        .sensor_enable(sensor_enable), .start(start), .stop(stop),
        .clear(clear), .target(target), .seed_count(seed_count),
        .target_reached(target_reached), .busy(busy),
        .hole_done(hole_done), .jam(jam), .overdrop(overdrop),
        .total_seeds(total_seeds), .hole_count(hole_count),
        .noise_count(noise_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: lane state 0=idle 1=armed 2=full; debounce as raw run lengths;
    // pulse widths from the edge index of the stable fall.
    int     m_st [N], m_tgt [N], m_cnt [N], m_run [N], m_pw [N];
    bit     m_jam [N], m_od [N], m_done [N], m_stable [N], m_last [N], m_pend [N];
    longint m_fall [N], m_jam_at [N];
    longint m_total, edge_n;
    int     m_holes, m_noise;

    task automatic cmp(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_st[i] = 0; m_tgt[i] = 0; m_cnt[i] = 0; m_run[i] = 0;
            m_pw[i] = 0; m_jam[i] = 0; m_od[i] = 0; m_done[i] = 0;
            m_stable[i] = 1; m_last[i] = 1; m_pend[i] = 0;
            m_fall[i] = 0; m_jam_at[i] = -1;
        end
        m_total = 0; m_holes = 0; m_noise = 0; edge_n = 0;
    endfunction

    function automatic void model_step();
        int ns = 0, nc = 0, nn = 0;
        bit sd [N], nz [N], jh [N];
        edge_n++;
        for (int i = 0; i < N; i++) begin
            sd[i] = 0; nz[i] = 0;
            if (m_pend[i] && sensor_enable) begin
                if (m_pw[i] < MINC) nz[i] = 1;
                else if (m_pw[i] <= MAXC) sd[i] = 1;
            end
            m_pend[i] = 0;
            jh[i] = (edge_n == m_jam_at[i]);
        end
        if (clear) begin
            for (int i = 0; i < N; i++) begin
                m_st[i] = 0; m_cnt[i] = 0; m_jam[i] = 0; m_od[i] = 0; m_done[i] = 0;
            end
            m_total = 0; m_holes = 0; m_noise = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                m_done[i] = 0;
                if (nz[i]) nn++;
                if (start[i]) begin
                    m_tgt[i] = int'(target[8*i +: 8]);
                    m_cnt[i] = 0; m_jam[i] = 0; m_od[i] = 0;
                    m_st[i] = (m_tgt[i] == 0) ? 2 : 1;
                end else begin
                    if (jh[i]) m_jam[i] = 1;
                    if (stop[i] && m_st[i] != 0) begin
                        m_st[i] = 0; m_done[i] = 1; nc++;
                    end else if (sd[i] && m_st[i] == 1) begin
                        m_cnt[i]++; ns++;
                        if (m_cnt[i] >= m_tgt[i]) m_st[i] = 2;
                    end else if (sd[i] && m_st[i] == 2) begin
                        if (m_cnt[i] < 255) m_cnt[i]++;
                        ns++; m_od[i] = 1;
                    end
                end
            end
            m_total = m_total + ns;
            if (m_total > 64'hFFFF_FFFF) m_total = 64'hFFFF_FFFF;
            m_holes = (m_holes + nc) % 65536;
            m_noise = (m_noise + nn > 65535) ? 65535 : m_noise + nn;
        end
        if (sensor_enable) begin
            for (int i = 0; i < N; i++) begin
                bit r;
                longint w;
                r = sensor_n[i];
                if (r == m_last[i]) m_run[i]++;
                else begin m_run[i] = 1; m_last[i] = r; end
                if (r != m_stable[i] && m_run[i] >= D) begin
                    m_stable[i] = r;
                    if (!r) begin
                        m_fall[i] = edge_n;
                        m_jam_at[i] = edge_n + MAXC + 2;
                    end else begin
                        w = edge_n - m_fall[i];
                        if (w <= MAXC) m_jam_at[i] = -1;
                        if (w > MAXC + 1) w = MAXC + 1;
                        m_pw[i] = int'(w);
                        m_pend[i] = 1;
                    end
                end
            end
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    // Every cycle, compare all outputs against the model
    always @(negedge clk) begin : cmp_blk
        logic [8*N-1:0] e_sc;
        logic [N-1:0]   e_tr, e_bz, e_hd, e_jm, e_od;
        for (int i = 0; i < N; i++) begin
            e_sc[8*i +: 8] = 8'(m_cnt[i]);
            e_tr[i] = (m_st[i] == 2);
            e_bz[i] = (m_st[i] != 0);
            e_hd[i] = m_done[i];
            e_jm[i] = m_jam[i];
            e_od[i] = m_od[i];
        end
        cmp("seed_count", 32'(seed_count), 32'(e_sc));
        cmp("target_reached", 32'(target_reached), 32'(e_tr));
        cmp("busy", 32'(busy), 32'(e_bz));
        cmp("hole_done", 32'(hole_done), 32'(e_hd));
        cmp("jam", 32'(jam), 32'(e_jm));
        cmp("overdrop", 32'(overdrop), 32'(e_od));
        cmp("total_seeds", total_seeds, 32'(m_total));
        cmp("hole_count", 32'(hole_count), 32'(m_holes));
        cmp("noise_count", 32'(noise_count), 32'(m_noise));
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic arm(logic [N-1:0] m, logic [7:0] t0, logic [7:0] t1);
        start = m; target = {t1, t0};
        tick(1);
        start = '0;
    endtask

    task automatic close(logic [N-1:0] m);
        stop = m;
        tick(1);
        stop = '0;
    endtask

    task automatic pulse(logic [N-1:0] m, int len);
        sensor_n = ~m;
        tick(len);
        sensor_n = '1;
        tick(8);
    endtask

    int seg [N];
    int lows [13] = '{2, 3, 5, 6, 9, 10, 11, 20, 30, 50, 51, 52, 60};

    initial begin
        model_reset();
        tick(3);
        cmp("rst_total", total_seeds, 32'd0);
        cmp("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick(2);

        arm(2'b01, 8'd2, 8'd0);
        cmp("arm_busy", 32'(busy), 32'd1);
        pulse(2'b01, 20);
        cmp("seed1", 32'(seed_count[7:0]), 32'd1);
        pulse(2'b01, 20);
        cmp("seed2", 32'(seed_count[7:0]), 32'd2);
        cmp("full0", 32'(target_reached), 32'd1);
        cmp("total2", total_seeds, 32'd2);
        cmp("mdl_total2", 32'(m_total), 32'd2);

        pulse(2'b01, 20);
        cmp("seed3", 32'(seed_count[7:0]), 32'd3);
        cmp("overdrop0", 32'(overdrop), 32'd1);
        close(2'b01);
        cmp("done_pulse", 32'(hole_done), 32'd1);
        cmp("holes1", 32'(hole_count), 32'd1);
        cmp("mdl_holes1", 32'(m_holes), 32'd1);
        tick(1);
        cmp("done_gone", 32'(hole_done), 32'd0);
        cmp("seed_hold", 32'(seed_count[7:0]), 32'd3);

        arm(2'b10, 8'd0, 8'd5);
        pulse(2'b10, 3);
        cmp("glitch", 32'(noise_count), 32'd0);
        pulse(2'b10, 6);
        cmp("noise1", 32'(noise_count), 32'd1);
        cmp("seed_l1", 32'(seed_count[15:8]), 32'd0);

        pulse(2'b10, 60);
        cmp("jam1", 32'(jam), 32'd2);
        cmp("jam_noseed", 32'(seed_count[15:8]), 32'd0);
        arm(2'b10, 8'd0, 8'd5);
        cmp("jam_clr", 32'(jam), 32'd0);

        arm(2'b11, 8'd3, 8'd3);
        pulse(2'b11, 20);
        cmp("dual_total", total_seeds, 32'd5);
        close(2'b11);
        cmp("dual_done", 32'(hole_done), 32'd3);
        cmp("dual_holes", 32'(hole_count), 32'd3);

        arm(2'b01, 8'd0, 8'd0);
        cmp("tgt0_full", 32'(target_reached), 32'd1);
        sensor_n = 2'b10;
        tick(20);
        sensor_n = '1;
        tick(D);
        arm(2'b01, 8'd3, 8'd0);
        cmp("drop_seed", 32'(seed_count[7:0]), 32'd0);
        cmp("drop_total", total_seeds, 32'd5);

        sensor_enable = 1'b0;
        sensor_n = 2'b10;
        tick(20);
        sensor_n = '1;
        tick(4);
        sensor_enable = 1'b1;
        tick(8);
        cmp("en_off", total_seeds, 32'd5);

        arm(2'b10, 8'd0, 8'd3);
        pulse(2'b10, 20);
        cmp("pre_clr", total_seeds, 32'd6);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        cmp("clr_total", total_seeds, 32'd0);
        cmp("clr_holes", 32'(hole_count), 32'd0);
        cmp("clr_noise", 32'(noise_count), 32'd0);
        cmp("clr_busy", 32'(busy), 32'd0);

        for (int i = 0; i < N; i++) seg[i] = 0;
        for (int c = 0; c < 5000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (seg[i] == 0) begin
                    sensor_n[i] = ~sensor_n[i];
                    seg[i] = sensor_n[i] ? int'($urandom_range(1, 15))
                                         : lows[$urandom_range(0, 12)];
                end
                seg[i]--;
                start[i] = ($urandom_range(0, 39) == 0);
                stop[i] = ($urandom_range(0, 29) == 0);
            end
            clear = ($urandom_range(0, 799) == 0);
            target = {8'($urandom_range(0, 4)), 8'($urandom_range(0, 4))};
            if (c == 3000) rst_n = 1'b0;
            if (c == 3003) rst_n = 1'b1;
            tick(1);
        end
        start = '0; stop = '0; clear = 1'b0; sensor_n = '1;
        tick(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
